// File: rtl/switch_pkg.sv
// Shared widths, word layout and scheduler state encoding for the egress metadata path.
package switch_pkg;

  localparam int PORT_W    = 2;
  localparam int META_W    = 29;
  localparam int VALID_BIT = 31;
  localparam int PORT_LSB  = 29;

  typedef logic [31:0]       meta_word_t;
  typedef logic [META_W-1:0] meta_t;

  typedef enum logic {IDLE, PRESENT} sched_state_t;

  function automatic meta_word_t pack_word(input logic vld, input logic [PORT_W-1:0] port,
                                           input meta_t meta);
    return {vld, port, meta};
  endfunction

endpackage

// File: rtl/egress_meta_scheduler_if.sv
// Egress-side push bus plus the software read word/ack path of the metadata scheduler.
interface egress_meta_scheduler_if
  import switch_pkg::*;
#(
  parameter int NUM_PORTS = 4
) ();

  logic [NUM_PORTS-1:0]             meta_valid;
  logic [NUM_PORTS-1:0][META_W-1:0] meta_data;
  logic [NUM_PORTS-1:0]             meta_ready;
  meta_word_t                       interface_in;
  logic                             interface_out_ack;
  logic [15:0]                      drop_count;

  modport master (
    output meta_valid, meta_data, interface_out_ack,
    input  meta_ready, interface_in, drop_count
  );

  modport slave (
    input  meta_valid, meta_data, interface_out_ack,
    output meta_ready, interface_in, drop_count
  );

endinterface

// File: rtl/egress_meta_scheduler_meta_fifo.sv
// Per-port record FIFO with synchronous clear; read data is the head entry (show-ahead).
// Full refuses push even when popping the same cycle; simultaneous push/pop keeps the count.
module meta_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 29
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok && !pop_ok)      cnt_d = cnt_q + (AW+1)'(1);
    else if (!push_ok && pop_ok) cnt_d = cnt_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/egress_meta_scheduler.sv
// Round-robin picks one buffered egress record into a holding register polled by software.
// Latency: push to held word in 2 edges; an entry retires only on the first ack edge after a valid read.
module egress_meta_scheduler
  import switch_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    experimenting,
  egress_meta_scheduler_if.slave  bus
);

  logic [NUM_PORTS-1:0] fifo_full, fifo_empty, fifo_push, fifo_pop, drop;
  meta_t                fifo_rdata [NUM_PORTS];

  sched_state_t         state_q, state_d;
  logic                 hold_valid_q, hold_valid_d;
  logic [PORT_W-1:0]    hold_port_q, hold_port_d;
  meta_t                hold_meta_q, hold_meta_d;
  logic [PORT_W-1:0]    rr_last_q, rr_last_d;
  logic [15:0]          drop_count_q, drop_count_d;
  logic [16:0]          drop_sum;
  logic                 ack_d_q, seen_valid_q;
  logic                 consume, grant_vld;
  logic [PORT_W-1:0]    grant, idx;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_fifo
    meta_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(META_W)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (!experimenting),
      .push    (fifo_push[p]),
      .pop     (fifo_pop[p]),
      .wdata   (bus.meta_data[p]),
      .rdata   (fifo_rdata[p]),
      .full    (fifo_full[p]),
      .empty   (fifo_empty[p])
    );
  end

  assign bus.meta_ready   = experimenting ? ~fifo_full : '0;
  assign fifo_push        = bus.meta_valid & bus.meta_ready;
  assign drop             = experimenting ? (bus.meta_valid & fifo_full) : '0;
  assign bus.interface_in = pack_word(hold_valid_q, hold_port_q, hold_meta_q);
  assign bus.drop_count   = drop_count_q;

  // Rising ack only counts if the read it answers saw a valid word.
  assign consume = bus.interface_out_ack && !ack_d_q && seen_valid_q;

  always_comb begin
    drop_sum = {1'b0, drop_count_q};
    for (int p = 0; p < NUM_PORTS; p++) drop_sum = drop_sum + 17'(drop[p]);
    drop_count_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    idx       = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      idx = PORT_W'((int'(rr_last_q) + i) % NUM_PORTS);
      if (!grant_vld && !fifo_empty[idx]) begin
        grant_vld = 1'b1;
        grant     = idx;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    hold_valid_d = hold_valid_q;
    hold_port_d  = hold_port_q;
    hold_meta_d  = hold_meta_q;
    rr_last_d    = rr_last_q;
    fifo_pop     = '0;
    if (!experimenting) begin
      state_d      = IDLE;
      hold_valid_d = 1'b0;
      hold_port_d  = '0;
      hold_meta_d  = '0;
    end else begin
      case (state_q)
        IDLE: if (grant_vld) begin
          fifo_pop[grant] = 1'b1;
          hold_valid_d    = 1'b1;
          hold_port_d     = grant;
          hold_meta_d     = fifo_rdata[grant];
          rr_last_d       = grant;
          state_d         = PRESENT;
        end
        PRESENT: if (consume) begin
          hold_valid_d = 1'b0;
          hold_port_d  = '0;
          hold_meta_d  = '0;
          state_d      = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      hold_valid_q <= 1'b0;
      hold_port_q  <= '0;
      hold_meta_q  <= '0;
      rr_last_q    <= PORT_W'(NUM_PORTS - 1);
      drop_count_q <= '0;
      ack_d_q      <= 1'b0;
      seen_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_valid_q <= hold_valid_d;
      hold_port_q  <= hold_port_d;
      hold_meta_q  <= hold_meta_d;
      rr_last_q    <= rr_last_d;
      drop_count_q <= drop_count_d;
      ack_d_q      <= bus.interface_out_ack;
      seen_valid_q <= hold_valid_q;
    end
  end

endmodule
